// File: rtl/fifo_2048.sv
// fifo_2048: 2048 x 8 first-word-fall-through FIFO, AXI-Stream handshakes, per-byte last.
// Define FIFO_COUNT_EN to add the fill_count occupancy output.
module fifo_2048 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic                  input_tvalid,
    output logic                  input_tready,
    input  logic                  input_tlast,
    input  logic                  r_en,
`ifdef FIFO_COUNT_EN
    output logic [ADDR_WIDTH:0]   fill_count,
`endif
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    output logic                  output_last,
    input  logic                  output_ready
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic                empty, full;
    logic                wr_fire, rd_fire;

    // Extra MSB is a wrap bit: same address with differing wrap means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0])
                && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    assign input_tready = !full;
    assign output_valid = !empty;

    assign wr_fire = w_en & input_tvalid & input_tready;
    assign rd_fire = r_en & output_ready & output_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {input_tlast, input_tdata};
        end
    end

    // Head entry falls through combinationally; stale entry shows when empty.
    assign {output_last, output_data} = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

`ifdef FIFO_COUNT_EN
    assign fill_count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_fifo_2048.sv
// tb_fifo_2048: directed vector table plus multi-cycle sequences for fifo_2048.
// Define FIFO_COUNT_EN to also check fill_count.
module tb_fifo_2048;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       w_en, input_tvalid, input_tlast, r_en, output_ready;
    logic [7:0] input_tdata;
    logic       input_tready, output_valid, output_last;
    logic [7:0] output_data;
`ifdef FIFO_COUNT_EN
    logic [11:0] fill_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    fifo_2048 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .w_en         (w_en),
        .input_tdata  (input_tdata),
        .input_tvalid (input_tvalid),
        .input_tready (input_tready),
        .input_tlast  (input_tlast),
        .r_en         (r_en),
`ifdef FIFO_COUNT_EN
        .fill_count   (fill_count),
`endif
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_last  (output_last),
        .output_ready (output_ready)
    );

    typedef struct {
        logic       w, v, l;
        logic [7:0] d;
        logic       r, rdy;
        logic       e_rdy, e_vld, chk_d;
        logic [7:0] e_d;
        logic       e_l;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at negedge; checks outputs against the queue model, then clocks once.
    task automatic cycle(input logic w, input logic v, input logic l,
                         input logic [7:0] d, input logic r, input logic rdy);
        logic wf, rf;
        w_en = w; input_tvalid = v; input_tlast = l; input_tdata = d;
        r_en = r; output_ready = rdy;
        #1;
        chk("tready", input_tready, q.size() < 2048);
        chk("valid", output_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("data", output_data, q[0][7:0]);
            chk("last", output_last, q[0][8]);
        end
`ifdef FIFO_COUNT_EN
        chk("fill_count", fill_count, q.size());
`endif
        wf = w & v & (q.size() < 2048);
        rf = r & rdy & (q.size() != 0);
        @(posedge clk);
        if (rf) void'(q.pop_front());
        if (wf) q.push_back({l, d});
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq;
        // w v l d        r rdy  rdy vld chk d     l
        tbl[0] = '{1, 1, 0, 8'hA1, 0, 0, 1, 0, 0, 8'h00, 0};
        tbl[1] = '{1, 1, 1, 8'hA2, 0, 0, 1, 1, 1, 8'hA1, 0};
        tbl[2] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'hA1, 0};
        tbl[3] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 8'hA2, 1};
        tbl[4] = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0};
        tbl[5] = '{1, 1, 0, 8'h55, 0, 1, 1, 0, 0, 8'h00, 0};
        tbl[6] = '{0, 0, 0, 8'h00, 0, 1, 1, 1, 1, 8'h55, 0};
        tbl[7] = '{0, 0, 0, 8'h00, 1, 0, 1, 1, 1, 8'h55, 0};
        tbl[8] = '{0, 1, 0, 8'h66, 1, 1, 1, 1, 1, 8'h55, 0};
        tbl[9] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0};

        reset_n = 1'b1;
        w_en = 0; input_tvalid = 0; input_tlast = 0; input_tdata = 0;
        r_en = 0; output_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_tready", input_tready, 1);
        chk("reset_valid", output_valid, 0);
`ifdef FIFO_COUNT_EN
        chk("reset_fill", fill_count, 0);
`endif

        foreach (tbl[i]) begin
            w_en = tbl[i].w; input_tvalid = tbl[i].v; input_tlast = tbl[i].l;
            input_tdata = tbl[i].d; r_en = tbl[i].r; output_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_tready", i), input_tready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_valid", i), output_valid, tbl[i].e_vld);
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d_data", i), output_data, tbl[i].e_d);
                chk($sformatf("vec%0d_last", i), output_last, tbl[i].e_l);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset mid-operation discards contents at once.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 8'(i + 7), 0, 0);
        reset_n = 1'b1;
        #1;
        chk("midrst_valid", output_valid, 0);
        chk("midrst_tready", input_tready, 1);
`ifdef FIFO_COUNT_EN
        chk("midrst_fill", fill_count, 0);
`endif
        @(negedge clk);
        reset_n = 1'b0;
        q.delete();

        // Fill with 2049 writes; the last one must be dropped.
        for (int i = 1; i <= 2049; i++) begin
            chk("fill_tready", input_tready, i <= 2048);
            cycle(1, 1, 0, 8'(i), 0, 0);
        end
        for (int i = 0; i < 30; i++) cycle(1, 1, 0, 8'hEE, 0, 0);
        chk("full_tready", input_tready, 0);
        chk("full_count", q.size(), 2048);

        for (int i = 1; i <= 2048; i++) begin
            chk("drain_data", output_data, i % 256);
            cycle(0, 0, 0, 8'h00, 1, 1);
        end
        chk("drained_valid", output_valid, 0);
        chk("drained_tready", input_tready, 1);

        // Streaming pass-through advances pointers so the half-full run wraps.
        seq = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            cycle(1, 1, seq[0], seq, 1, 1);
            seq++;
        end
        while (q.size() < 1024) begin
            cycle(1, 1, seq[0], seq, 0, 0);
            seq++;
        end
        for (int i = 0; i < 100; i++) begin
            cycle(1, 1, seq[0], seq, 1, 1);
            seq++;
            chk("half_occupancy", q.size(), 1024);
        end
        cycle(0, 0, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_2048.md
# fifo_2048

Synchronous single-clock 2048 x 8-bit first-word-fall-through FIFO with AXI-Stream-style handshakes. It buffers byte streams, with a per-byte `last` marker, between a producer and a consumer in the same clock domain. Additional enable qualifiers `w_en` and `r_en` gate the write and read sides.

## Interface
- `DATA_WIDTH`, default 8: payload width in bits.
- `DEPTH`, default 2048: number of entries. Must be a power of two.
- `ADDR_WIDTH`, default 11: log2(`DEPTH`).

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-high reset. The name keeps the codebase's `_n` suffix, but asserting it **high** resets the block.
- `w_en`  in  1: write-side enable.
- `input_tdata`  in  `DATA_WIDTH`: write data.
- `input_tvalid`  in  1: producer has data.
- `input_tready`  out  1: FIFO can accept data (not full).
- `input_tlast`  in  1: end-of-packet marker, stored with the byte.
- `r_en`  in  1: read-side enable.
- `output_data`  out  `DATA_WIDTH`: head-of-queue data.
- `output_valid`  out  1: FIFO not empty.
- `output_last`  out  1: `last` flag stored with the head entry.
- `output_ready`  in  1: consumer accepts the head entry.

## Operation
- Storage: `DEPTH` entries of `DATA_WIDTH`+1 bits, holding {last, data}.
- Pointers:
  - `wr_ptr` and `rd_ptr` are `ADDR_WIDTH`+1 bits wide. The extra MSB is a wrap bit.
  - empty = (`wr_ptr` == `rd_ptr`).
  - full = (address bits equal) and (wrap bits differ).
- Write fire: `w_en & input_tvalid & input_tready`. It stores {`input_tlast`, `input_tdata`} at `wr_ptr[ADDR_WIDTH-1:0]`, then `wr_ptr` increments.
- Read fire: `r_en & output_ready & output_valid`. `rd_ptr` increments.
- `input_tready` = !full. It does not depend on `w_en`.
- `output_valid` = !empty. It does not depend on `r_en`.
- `output_data` and `output_last` present `mem[rd_ptr]` (first-word fall-through). When empty, their values are don't-care; the implementation drives the stale entry.
- Write attempts while full are dropped silently. No error flag, no corruption.
- Read attempts while empty are ignored. Pointers are unchanged.
- Simultaneous read fire and write fire:
  - Both take effect; occupancy is unchanged.
  - When full, `input_tready`=0, so only the read fires.
  - When empty, only the write fires.
- Pointer wrap-around is natural binary rollover modulo 2·`DEPTH`.
- Data is never transformed. Byte order and the `last` flag are preserved exactly.

## Timing
- Reset (`reset_n`=1, asynchronous):
  - `wr_ptr`=0, `rd_ptr`=0.
  - `input_tready`=1, `output_valid`=0.
  - Memory contents are not cleared.
- Reset mid-operation empties the FIFO immediately. Contents are discarded.
- Write-to-read latency: a byte written at edge N is visible on `output_data`, with `output_valid`=1, after edge N. It can be consumed at edge N+1.
- Flag updates:
  - `input_tready` falls in the cycle after the write that fills the FIFO. It rises in the cycle after the first read from full.
  - `output_valid` falls in the cycle after the read of the last entry.
- Throughput: one write and one read per clock, sustained.

## Configuration
- Macro `FIFO_COUNT_EN`.
- Defined: adds output `fill_count` [`ADDR_WIDTH`:0], equal to `wr_ptr - rd_ptr`.
  - Range 0..2048.
  - Reset value 0.
  - Updated on the same edge as the pointers.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert `reset_n`=1 for 3 cycles, then release. Required: `input_tready`=1, `output_valid`=0, `fill_count`=0.
- Fill overflow:
  - Stimulus: hold `w_en`=1 and `input_tvalid`=1, and drive data 1,2,3,… (8-bit wrap) for 2049 cycles.
  - Required: 2048 bytes accepted, `input_tready`=0 after the 2048th, the 2049th byte dropped, `fill_count`=2048.
- Write while full: 30 further write attempts. Required: `input_tready` stays 0, contents are unchanged, `fill_count`=2048.
- Drain:
  - Stimulus: `w_en`=0, `r_en`=1, `output_ready`=1 for 2048 cycles.
  - Required: outputs are 1,2,…,255,0,1,… (i mod 256 for i=1..2048), in order.
  - Then `output_valid`=0 and `input_tready`=1.
- Packet marker: write bytes 0xA1 and 0xA2 with `input_tlast`=0,1. Required: on readout, `output_last`=0 then 1.
- Simultaneous read/write at half-full (1024 entries) for 100 cycles. Required: `fill_count` stays 1024, data order is preserved, and the pointers wrap correctly past 2047.
